// File: rtl/hw2_result_checker.sv
// Self-checking result monitor for a (a +/- b) * c datapath: predicts each accepted vector,
// delays the prediction by LATENCY clocks and compares it with the DUT result d.
module hw2_result_checker #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned NUM_VEC = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 vld,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic                 s,
    input  logic [2*WIDTH-1:0]   d,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          fail_cnt,
    output logic [15:0]          ff_idx,
    output logic [2*WIDTH-1:0]   ff_exp,
    output logic [2*WIDTH-1:0]   ff_got,
    output logic                 ff_vld
);
    localparam int unsigned RW         = 2 * WIDTH;
    localparam int          LAT        = int'(LATENCY);
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [15:0]     idx_q, idx_d;
    logic [2:0]      drain_q, drain_d;
    logic [15:0]     pass_q, pass_d;
    logic [15:0]     fail_q, fail_d;
    logic [15:0]     ff_idx_q, ff_idx_d;
    logic [RW-1:0]   ff_exp_q, ff_exp_d;
    logic [RW-1:0]   ff_got_q, ff_got_d;
    logic            ff_vld_q, ff_vld_d;
    logic            mismatch_q, mismatch_d;

    logic            pipe_vld_q [LAT];
    logic            pipe_vld_d [LAT];
    logic [RW-1:0]   pipe_exp_q [LAT];
    logic [RW-1:0]   pipe_exp_d [LAT];
    logic [15:0]     pipe_idx_q [LAT];
    logic [15:0]     pipe_idx_d [LAT];

    logic            accept;
    logic [RW-1:0]   a_x, b_x, c_x, op_res, exp_val;

    // Operands widen before the add/subtract so the carry of a+b survives.
    always_comb begin
        a_x     = {{WIDTH{1'b0}}, a};
        b_x     = {{WIDTH{1'b0}}, b};
        c_x     = {{WIDTH{1'b0}}, c};
        op_res  = s ? (a_x + b_x) : (a_x - b_x);
        exp_val = op_res * c_x;
    end

    assign accept = (state_q == StRun) && vld;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ff_idx_d   = ff_idx_q;
        ff_exp_d   = ff_exp_q;
        ff_got_d   = ff_got_q;
        ff_vld_d   = ff_vld_q;
        mismatch_d = 1'b0;

        pipe_vld_d[0] = accept;
        pipe_exp_d[0] = exp_val;
        pipe_idx_d[0] = idx_q;
        for (int i = 1; i < LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_exp_d[i] = pipe_exp_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end

        if (pipe_vld_q[LAT-1]) begin
            if (pipe_exp_q[LAT-1] == d) begin
                if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
            end else begin
                mismatch_d = 1'b1;
                if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
                if (!ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_idx_d = pipe_idx_q[LAT-1];
                    ff_exp_d = pipe_exp_q[LAT-1];
                    ff_got_d = d;
                end
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRun;
                    idx_d    = '0;
                    pass_d   = '0;
                    fail_d   = '0;
                    ff_idx_d = '0;
                    ff_exp_d = '0;
                    ff_got_d = '0;
                    ff_vld_d = 1'b0;
                    for (int i = 0; i < LAT; i++) pipe_vld_d[i] = 1'b0;
                end
            end
            StRun: begin
                if (vld) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_LAST) state_d = StDone;
                else                       drain_d = drain_q + 3'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            drain_q    <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_idx_q   <= '0;
            ff_exp_q   <= '0;
            ff_got_q   <= '0;
            ff_vld_q   <= 1'b0;
            mismatch_q <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_exp_q[i] <= '0;
                pipe_idx_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drain_q    <= drain_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ff_idx_q   <= ff_idx_d;
            ff_exp_q   <= ff_exp_d;
            ff_got_q   <= ff_got_d;
            ff_vld_q   <= ff_vld_d;
            mismatch_q <= mismatch_d;
            for (int i = 0; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_d[i];
                pipe_exp_q[i] <= pipe_exp_d[i];
                pipe_idx_q[i] <= pipe_idx_d[i];
            end
        end
    end

    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign done     = (state_q == StDone);
    assign mismatch = mismatch_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign ff_idx   = ff_idx_q;
    assign ff_exp   = ff_exp_q;
    assign ff_got   = ff_got_q;
    assign ff_vld   = ff_vld_q;

endmodule

// File: tb/tb_hw2_result_checker.sv
// Bench for hw2_result_checker: two instances (LATENCY 1 and 3) fed by a behavioural DUT model
// with error injection; a scoreboard predicts every compare's cycle and outcome.
module tb_hw2_result_checker;
    localparam int unsigned W  = 8;
    localparam int unsigned L0 = 1;
    localparam int unsigned N0 = 8;
    localparam int unsigned L1 = 3;
    localparam int unsigned N1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, vld = 1'b0, s = 1'b0, start0 = 1'b0, start1 = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic [15:0]  xmask = '0;
    logic [15:0]  dd0, dd1, p1a, p1b;

    logic         busy0, done0, mm0, fv0, busy1, done1, mm1, fv1;
    logic [15:0]  pc0, fc0, fi0, fe0, fg0, pc1, fc1, fi1, fe1, fg1;

    hw2_result_checker #(.WIDTH(W), .LATENCY(L0), .NUM_VEC(N0)) u_l1 (
        .clk(clk), .rst(rst), .start(start0), .vld(vld), .a(a), .b(b), .c(c), .s(s), .d(dd0),
        .busy(busy0), .done(done0), .mismatch(mm0), .pass_cnt(pc0), .fail_cnt(fc0),
        .ff_idx(fi0), .ff_exp(fe0), .ff_got(fg0), .ff_vld(fv0)
    );

    hw2_result_checker #(.WIDTH(W), .LATENCY(L1), .NUM_VEC(N1)) u_l3 (
        .clk(clk), .rst(rst), .start(start1), .vld(vld), .a(a), .b(b), .c(c), .s(s), .d(dd1),
        .busy(busy1), .done(done1), .mismatch(mm1), .pass_cnt(pc1), .fail_cnt(fc1),
        .ff_idx(fi1), .ff_exp(fe1), .ff_got(fg1), .ff_vld(fv1)
    );

    function automatic logic [15:0] model(input logic [7:0] ta, input logic [7:0] tb,
                                          input logic [7:0] tc, input logic ts);
        logic [15:0] x;
        x = ts ? ({8'h00, ta} + {8'h00, tb}) : ({8'h00, ta} - {8'h00, tb});
        return x * {8'h00, tc};
    endfunction

    // Behavioural DUT: result appears LATENCY clocks after its operands, optionally corrupted.
    always @(posedge clk) begin
        dd0 <= model(a, b, c, s) ^ xmask;
        p1a <= model(a, b, c, s) ^ xmask;
        p1b <= p1a;
        dd1 <= p1b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          inst;
        logic [15:0] exp;
        logic [15:0] got;
        logic        err;
        int          idx;
        int          cyc;
    } ent_t;

    ent_t sb[$];
    int   n_checks = 0, n_errors = 0;
    logic run [2] = '{1'b0, 1'b0};
    int   acc [2] = '{0, 0};
    int   prev_tot [2] = '{0, 0};
    logic first_seen [2] = '{1'b0, 1'b0};
    int   first_idx [2] = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic observe(input int i, input logic [15:0] pc, input logic [15:0] fc,
                           input logic [15:0] fi, input logic [15:0] fe, input logic [15:0] fg,
                           input logic mm, input logic fv);
        int   tot;
        ent_t e;
        tot = int'(pc) + int'(fc);
        if (tot > prev_tot[i]) begin
            if (sb.size() == 0 || sb[0].inst != i) begin
                check_eq($sformatf("i%0d_spurious_cmp", i), tot, prev_tot[i]);
            end else begin
                e = sb.pop_front();
                check_eq($sformatf("i%0d_cmp_cycle_v%0d", i, e.idx), cyc, e.cyc);
                check_eq($sformatf("i%0d_cmp_step_v%0d", i, e.idx), tot - prev_tot[i], 1);
                check_eq($sformatf("i%0d_mismatch_v%0d", i, e.idx), mm, e.err);
                if (e.err) begin
                    if (!first_seen[i]) begin
                        first_seen[i] = 1'b1;
                        first_idx[i]  = e.idx;
                        check_eq($sformatf("i%0d_ff_exp", i), fe, e.exp);
                        check_eq($sformatf("i%0d_ff_got", i), fg, e.got);
                    end
                    check_eq($sformatf("i%0d_ff_idx", i), fi, first_idx[i]);
                    check_eq($sformatf("i%0d_ff_vld", i), fv, 1);
                end
            end
        end else if (mm) begin
            check_eq($sformatf("i%0d_spurious_mismatch", i), mm, 0);
        end
        prev_tot[i] = tot;
    endtask

    always @(negedge clk) begin
        observe(0, pc0, fc0, fi0, fe0, fg0, mm0, fv0);
        observe(1, pc1, fc1, fi1, fe1, fg1, mm1, fv1);
    end

    task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                         input logic ts, input logic [15:0] mask, input logic v);
        ent_t e;
        int   i;
        @(negedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        a = ta; b = tb; c = tc; s = ts; xmask = mask; vld = v;
        if (v && (run[0] || run[1])) begin
            i      = run[0] ? 0 : 1;
            e.inst = i;
            e.exp  = model(ta, tb, tc, ts);
            e.got  = e.exp ^ mask;
            e.err  = (mask != 16'h0);
            e.idx  = acc[i];
            e.cyc  = cyc + 1 + ((i == 0) ? int'(L0) : int'(L1));
            sb.push_back(e);
            acc[i]++;
            if (acc[i] == ((i == 0) ? int'(N0) : int'(N1))) run[i] = 1'b0;
        end
    endtask

    task automatic do_start(input int i);
        @(negedge clk); #1;
        vld = 1'b0;
        if (i == 0) start0 = 1'b1; else start1 = 1'b1;
        run[i] = 1'b1; acc[i] = 0; first_seen[i] = 1'b0;
    endtask

    task automatic rnd_good();
        drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 16'h0, 1'b1);
    endtask

    // After the last accept the instance must stay busy exactly lat cycles, then be done.
    task automatic check_drain(input int i, input int lat);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk); #1;
            vld = 1'b0;
            start0 = 1'b0; start1 = 1'b0;
            if (k == 0) begin
                if (i == 0) start0 = 1'b1; else start1 = 1'b1;
            end
            check_eq($sformatf("i%0d_drain_busy_%0d", i, k), (i == 0) ? busy0 : busy1, 1);
            check_eq($sformatf("i%0d_drain_done_%0d", i, k), (i == 0) ? done0 : done1, 0);
        end
        @(negedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        check_eq($sformatf("i%0d_done", i), (i == 0) ? done0 : done1, 1);
        check_eq($sformatf("i%0d_done_busy", i), (i == 0) ? busy0 : busy1, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_busy0", busy0, 0);
        check_eq("rst_done0", done0, 0);
        check_eq("rst_pass0", pc0, 0);
        check_eq("rst_fail0", fc0, 0);
        check_eq("rst_ffvld0", fv0, 0);
        check_eq("rst_mm0", mm0, 0);
        check_eq("rst_busy1", busy1, 0);
        check_eq("rst_pass1", pc1, 0);
        rst = 1'b0;

        // Run A: latency 1, eight vectors, errors on indices 2 and 5, one bubble.
        do_start(0);
        drive(8'd3, 8'd5, 8'd2, 1'b0, 16'h0, 1'b1);
        drive(8'd255, 8'd255, 8'd255, 1'b1, 16'h0, 1'b1);
        drive(8'd3, 8'd5, 8'd2, 1'b0, 16'd65532, 1'b1);
        rnd_good();
        drive(8'd0, 8'd0, 8'd0, 1'b0, 16'h0, 1'b0);
        rnd_good();
        drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 16'h0100, 1'b1);
        rnd_good();
        rnd_good();
        check_drain(0, int'(L0));
        check_eq("a_pass", pc0, 6);
        check_eq("a_fail", fc0, 2);
        check_eq("a_ff_idx", fi0, 2);
        check_eq("a_ff_exp", fe0, 16'd65532);
        check_eq("a_ff_got", fg0, 16'd0);
        check_eq("a_ff_vld", fv0, 1);

        // DONE must ignore vld and hold its results.
        repeat (3) drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 16'h00ff, 1'b1);
        check_eq("hold_pass", pc0, 6);
        check_eq("hold_fail", fc0, 2);
        check_eq("hold_done", done0, 1);

        // Reset after two accepts, with start and vld also asserted.
        do_start(0);
        rnd_good();
        rnd_good();
        @(negedge clk); #1;
        rst = 1'b1; start0 = 1'b1; vld = 1'b1;
        sb.delete();
        run[0] = 1'b0;
        @(negedge clk); #1;
        check_eq("mrst_busy", busy0, 0);
        check_eq("mrst_done", done0, 0);
        check_eq("mrst_pass", pc0, 0);
        check_eq("mrst_ffvld", fv0, 0);
        rst = 1'b0; start0 = 1'b0; vld = 1'b0;

        // Clean full run; a start pulse mid-run must be ignored.
        do_start(0);
        for (int k = 0; k < int'(N0); k++) begin
            rnd_good();
            if (k == 3) start0 = 1'b1;
        end
        check_drain(0, int'(L0));
        check_eq("b_pass", pc0, 8);
        check_eq("b_fail", fc0, 0);
        check_eq("b_ff_vld", fv0, 0);

        // Run C: latency 3, vld pattern 1,0,1,1, error on the last vector.
        do_start(1);
        rnd_good();
        drive(8'd0, 8'd0, 8'd0, 1'b0, 16'h0, 1'b0);
        rnd_good();
        drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 16'h0001, 1'b1);
        check_drain(1, int'(L1));
        check_eq("c_pass", pc1, 2);
        check_eq("c_fail", fc1, 1);
        check_eq("c_ff_idx", fi1, 2);
        check_eq("c_ff_vld", fv1, 1);
        check_eq("c_other_inst", pc0, 8);

        repeat (2) @(negedge clk);
        #1;
        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
